// File: rtl/vc_input_unit.sv
// Router input unit: per-VC circular flit buffers with head/tail packet FSMs,
// switch-allocator request generation, switch-traversal output and credit return.
module vc_input_unit #(
    parameter int  NUM_VCS      = 4,
    parameter int  NUM_OUTPORTS = 5,
    parameter int  BUF_DEPTH    = 4,
    parameter int  FLIT_WIDTH   = 32,
    localparam int VC_W         = $clog2(NUM_VCS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flit_in_valid,
    input  logic [FLIT_WIDTH-1:0]                flit_in,
    input  logic [VC_W-1:0]                      flit_in_vc,
    input  logic [NUM_OUTPORTS-1:0]              outport_ready,
    output logic [NUM_VCS-1:0][NUM_OUTPORTS-1:0] sa_requests,
    input  logic [NUM_VCS-1:0]                   sa_grant,
    output logic                                 flit_out_valid,
    output logic [FLIT_WIDTH-1:0]                flit_out,
    output logic [NUM_OUTPORTS-1:0]              flit_out_port,
    output logic                                 credit_out_valid,
    output logic [VC_W-1:0]                      credit_out_vc,
    output logic                                 overflow_err,
    output logic                                 proto_err,
    output logic                                 grant_err
);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int PEND_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(BUF_DEPTH);
    localparam logic [1:0]       FT_HEAD      = 2'b01;
    localparam logic [1:0]       FT_TAIL      = 2'b10;
    localparam logic [1:0]       FT_HEAD_TAIL = 2'b11;

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} vc_state_e;

    function automatic logic is_onehot(input logic [NUM_VCS-1:0] vec);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_VCS; i++) begin
            multi = multi | (seen & vec[i]);
            seen  = seen | vec[i];
        end
        return seen & ~multi;
    endfunction

    function automatic logic is_head(input logic [1:0] ftype);
        return (ftype == FT_HEAD) || (ftype == FT_HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] ftype);
        return (ftype == FT_TAIL) || (ftype == FT_HEAD_TAIL);
    endfunction

    vc_state_e                            state_q [NUM_VCS];
    vc_state_e                            state_d [NUM_VCS];
    logic [FLIT_WIDTH-1:0]                mem_q   [NUM_VCS][BUF_DEPTH];
    logic [NUM_VCS-1:0][PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [NUM_VCS-1:0][CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_VCS-1:0][NUM_OUTPORTS-1:0] route_q, route_d;
    logic [NUM_VCS-1:0][PEND_W-1:0]       pend_q, pend_d;

    logic                    flit_out_valid_q, flit_out_valid_d;
    logic [FLIT_WIDTH-1:0]   flit_out_q, flit_out_d;
    logic [NUM_OUTPORTS-1:0] flit_out_port_q, flit_out_port_d;
    logic                    credit_valid_q, credit_valid_d;
    logic [VC_W-1:0]         credit_vc_q, credit_vc_d;
    logic                    ovf_err_q, ovf_err_d;
    logic                    proto_err_q, proto_err_d;
    logic                    grant_err_q, grant_err_d;

    logic [NUM_VCS-1:0][FLIT_WIDTH-1:0]   front_s;
    logic [NUM_VCS-1:0][1:0]              ftype_s;
    logic [NUM_VCS-1:0][NUM_OUTPORTS-1:0] req_s;
    logic [NUM_VCS-1:0][PEND_W-1:0]       pend_tot_s;
    logic [NUM_VCS-1:0] empty_s, full_s, req_any_s, deq_s, drop_s, pop_s, wr_s, wr_en_s;
    logic               grant_onehot_s, ovf_hit_s, grant_bad_s;
    logic [VC_W-1:0]    gnt_vc_s;

    // Front-of-queue view of every VC buffer.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            front_s[v] = mem_q[v][rd_ptr_q[v]];
            ftype_s[v] = front_s[v][FLIT_WIDTH-1 -: 2];
            empty_s[v] = (cnt_q[v] == {CNT_W{1'b0}});
            full_s[v]  = (cnt_q[v] == FULL_CNT);
        end
    end

    // Packet FSM state and latched route.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                state_q[v] <= ST_IDLE;
            end
            route_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                state_q[v] <= state_d[v];
            end
            route_q <= route_d;
        end
    end

    // Packet FSM next state: a head at the front opens the packet, its tail departing closes it.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            state_d[v] = state_q[v];
            route_d[v] = route_q[v];
            case (state_q[v])
                ST_IDLE: begin
                    if (!empty_s[v] && is_head(ftype_s[v])) begin
                        state_d[v] = ST_ACTIVE;
                        route_d[v] = front_s[v][FLIT_WIDTH-3 -: NUM_OUTPORTS];
                    end else begin
                        state_d[v] = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (deq_s[v] && is_tail(ftype_s[v])) begin
                        state_d[v] = ST_IDLE;
                    end else begin
                        state_d[v] = ST_ACTIVE;
                    end
                end
                default: state_d[v] = ST_IDLE;
            endcase
        end
    end

    // Packet FSM outputs: allocator requests and protocol-drop pops of stray body/tail flits.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            if ((state_q[v] == ST_ACTIVE) && !empty_s[v]) begin
                req_s[v] = route_q[v] & outport_ready;
            end else begin
                req_s[v] = '0;
            end
            req_any_s[v] = |req_s[v];
            drop_s[v]    = (state_q[v] == ST_IDLE) && !empty_s[v] && !is_head(ftype_s[v]);
        end
    end

    // Buffer bookkeeping, grant qualification, traversal output and credit selection.
    always_comb begin
        grant_onehot_s   = is_onehot(sa_grant);
        ovf_hit_s        = 1'b0;
        gnt_vc_s         = '0;
        flit_out_d       = '0;
        flit_out_port_d  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            deq_s[v]      = grant_onehot_s & sa_grant[v] & req_any_s[v];
            pop_s[v]      = deq_s[v] | drop_s[v];
            wr_s[v]       = flit_in_valid && (flit_in_vc == VC_W'(v));
            wr_en_s[v]    = wr_s[v] & (~full_s[v] | pop_s[v]);
            ovf_hit_s     = ovf_hit_s | (wr_s[v] & ~wr_en_s[v]);
            wr_ptr_d[v]   = wr_en_s[v] ? (wr_ptr_q[v] + PTR_W'(1)) : wr_ptr_q[v];
            rd_ptr_d[v]   = pop_s[v] ? (rd_ptr_q[v] + PTR_W'(1)) : rd_ptr_q[v];
            cnt_d[v]      = cnt_q[v] + CNT_W'(wr_en_s[v]) - CNT_W'(pop_s[v]);
            flit_out_d      = flit_out_d | ({FLIT_WIDTH{deq_s[v]}} & front_s[v]);
            flit_out_port_d = flit_out_port_d | ({NUM_OUTPORTS{deq_s[v]}} & route_q[v]);
            gnt_vc_s        = gnt_vc_s | (deq_s[v] ? VC_W'(v) : {VC_W{1'b0}});
            pend_tot_s[v]   = pend_q[v] + PEND_W'(drop_s[v]);
            pend_d[v]       = pend_tot_s[v];
        end
        flit_out_valid_d = |deq_s;
        grant_bad_s      = (sa_grant != '0) && (!grant_onehot_s || ((sa_grant & req_any_s) == '0));

        // Grant credits win; drop credits wait in per-VC counters, lowest VC first.
        if (flit_out_valid_d) begin
            credit_valid_d = 1'b1;
            credit_vc_d    = gnt_vc_s;
        end else begin
            credit_valid_d = 1'b0;
            credit_vc_d    = '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                if (!credit_valid_d && (pend_tot_s[v] != {PEND_W{1'b0}})) begin
                    credit_valid_d = 1'b1;
                    credit_vc_d    = VC_W'(v);
                    pend_d[v]      = pend_tot_s[v] - PEND_W'(1);
                end else begin
                    pend_d[v]      = pend_tot_s[v];
                end
            end
        end

        ovf_err_d   = ovf_err_q | ovf_hit_s;
        proto_err_d = proto_err_q | (|drop_s);
        grant_err_d = grant_err_q | grant_bad_s;
    end

    // Pointers, occupancy, pending drop credits and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            cnt_q            <= '0;
            pend_q           <= '0;
            flit_out_valid_q <= 1'b0;
            flit_out_q       <= '0;
            flit_out_port_q  <= '0;
            credit_valid_q   <= 1'b0;
            credit_vc_q      <= '0;
            ovf_err_q        <= 1'b0;
            proto_err_q      <= 1'b0;
            grant_err_q      <= 1'b0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            cnt_q            <= cnt_d;
            pend_q           <= pend_d;
            flit_out_valid_q <= flit_out_valid_d;
            flit_out_q       <= flit_out_d;
            flit_out_port_q  <= flit_out_port_d;
            credit_valid_q   <= credit_valid_d;
            credit_vc_q      <= credit_vc_d;
            ovf_err_q        <= ovf_err_d;
            proto_err_q      <= proto_err_d;
            grant_err_q      <= grant_err_d;
        end
    end

    // Flit storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                for (int d = 0; d < BUF_DEPTH; d++) begin
                    mem_q[v][d] <= '0;
                end
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (wr_en_s[v]) begin
                    mem_q[v][wr_ptr_q[v]] <= flit_in;
                end
            end
        end
    end

    assign sa_requests      = req_s;
    assign flit_out_valid   = flit_out_valid_q;
    assign flit_out         = flit_out_q;
    assign flit_out_port    = flit_out_port_q;
    assign credit_out_valid = credit_valid_q;
    assign credit_out_vc    = credit_vc_q;
    assign overflow_err     = ovf_err_q;
    assign proto_err        = proto_err_q;
    assign grant_err        = grant_err_q;

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit: packet flow, overflow, protocol drop,
// backpressure, bad grants and asynchronous reset mid-packet.
module tb_vc_input_unit;
    localparam int NV = 4;
    localparam int NO = 5;
    localparam int FW = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flit_in_valid;
    logic [FW-1:0]          flit_in;
    logic [1:0]             flit_in_vc;
    logic [NO-1:0]          outport_ready;
    logic [NV-1:0][NO-1:0]  sa_requests;
    logic [NV-1:0]          sa_grant;
    logic                   flit_out_valid;
    logic [FW-1:0]          flit_out;
    logic [NO-1:0]          flit_out_port;
    logic                   credit_out_valid;
    logic [1:0]             credit_out_vc;
    logic                   overflow_err;
    logic                   proto_err;
    logic                   grant_err;

    int n_vec = 0;
    int n_err = 0;

    vc_input_unit #(.NUM_VCS(NV), .NUM_OUTPORTS(NO), .BUF_DEPTH(4), .FLIT_WIDTH(FW)) dut (
        .clk(clk), .reset(reset),
        .flit_in_valid(flit_in_valid), .flit_in(flit_in), .flit_in_vc(flit_in_vc),
        .outport_ready(outport_ready), .sa_requests(sa_requests), .sa_grant(sa_grant),
        .flit_out_valid(flit_out_valid), .flit_out(flit_out), .flit_out_port(flit_out_port),
        .credit_out_valid(credit_out_valid), .credit_out_vc(credit_out_vc),
        .overflow_err(overflow_err), .proto_err(proto_err), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [NO-1:0] r, input logic [24:0] p);
        return {t, r, p};
    endfunction

    task automatic check_out(input string tag, input logic [FW-1:0] f, input logic [NO-1:0] port, input logic [1:0] vc);
        check_val({tag, "_fvld"}, flit_out_valid, 1);
        check_val({tag, "_flit"}, flit_out, f);
        check_val({tag, "_port"}, flit_out_port, port);
        check_val({tag, "_cvld"}, credit_out_valid, 1);
        check_val({tag, "_cvc"}, credit_out_vc, vc);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_fvld"}, flit_out_valid, 0);
        check_val({tag, "_flit"}, flit_out, 0);
        check_val({tag, "_port"}, flit_out_port, 0);
        check_val({tag, "_cvld"}, credit_out_valid, 0);
        check_val({tag, "_cvc"}, credit_out_vc, 0);
        check_val({tag, "_req"}, sa_requests, 0);
        check_val({tag, "_ovf"}, overflow_err, 0);
        check_val({tag, "_proto"}, proto_err, 0);
        check_val({tag, "_gerr"}, grant_err, 0);
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        flit_in_valid = 1'b0;
        flit_in       = '0;
        flit_in_vc    = 2'd0;
        sa_grant      = '0;
        outport_ready = 5'b11111;
        step();
        step();
        reset = 1'b1;
    endtask

    logic [FW-1:0] fh, fb, ft;
    logic [FW-1:0] fq [4];

    initial begin
        reset = 1'b1; flit_in_valid = 1'b0; flit_in = '0; flit_in_vc = 2'd0;
        sa_grant = '0; outport_ready = 5'b11111;

        // Three-flit packet through VC1
        do_reset();
        check_quiet("rst");
        fh = mk(2'b01, 5'b00100, 25'h1);
        fb = mk(2'b00, 5'b00000, 25'h2);
        ft = mk(2'b10, 5'b00000, 25'h3);
        flit_in_valid = 1'b1; flit_in_vc = 2'd1; flit_in = fh;
        step();
        flit_in = fb; #1;
        check_val("pkt_req_early", sa_requests[1], 5'b00000);
        step();
        flit_in = ft; sa_grant = 4'b0010; #1;
        check_val("pkt_req", sa_requests[1], 5'b00100);
        step();
        flit_in_valid = 1'b0;
        check_out("pkt_f0", fh, 5'b00100, 2'd1);
        step();
        check_out("pkt_f1", fb, 5'b00100, 2'd1);
        step();
        check_out("pkt_f2", ft, 5'b00100, 2'd1);
        sa_grant = 4'b0000; #1;
        check_val("pkt_idle_req", sa_requests[1], 5'b00000);
        step();
        check_val("pkt_end_fvld", flit_out_valid, 0);
        check_val("pkt_end_cvld", credit_out_valid, 0);
        check_val("pkt_gerr", grant_err, 0);

        // Overflow on a full VC0 with no dequeue
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fq[i] = (i == 0) ? mk(2'b01, 5'b00010, 25'h10) : mk(2'b00, 5'b00000, 25'(32'h10 + i));
        end
        flit_in_valid = 1'b1; flit_in_vc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            flit_in = fq[i];
            step();
        end
        check_val("ovf_pre", overflow_err, 0);
        flit_in = mk(2'b00, 5'b00000, 25'h20);
        step();
        flit_in_valid = 1'b0;
        check_val("ovf_set", overflow_err, 1);
        sa_grant = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("ovf_drain%0d", i), fq[i], 5'b00010, 2'd0);
        end
        sa_grant = 4'b0000; #1;
        check_val("ovf_empty_req", sa_requests[0], 5'b00000);
        step();
        check_val("ovf_no_5th", flit_out_valid, 0);
        check_val("ovf_gerr", grant_err, 0);

        // Write to a full VC0 that dequeues in the same cycle
        do_reset();
        flit_in_valid = 1'b1; flit_in_vc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            flit_in = fq[i];
            step();
        end
        ft = mk(2'b10, 5'b00000, 25'h25);
        flit_in = ft; sa_grant = 4'b0001;
        step();
        flit_in_valid = 1'b0;
        check_val("full_wr_ovf", overflow_err, 0);
        check_out("full_wr_f0", fq[0], 5'b00010, 2'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check_out($sformatf("full_wr_f%0d", i), fq[i], 5'b00010, 2'd0);
        end
        step();
        check_out("full_wr_tail", ft, 5'b00010, 2'd0);
        sa_grant = 4'b0000; #1;
        check_val("full_wr_req_end", sa_requests[0], 5'b00000);
        check_val("full_wr_ovf_end", overflow_err, 0);

        // Stray body flit into idle VC2
        do_reset();
        flit_in_valid = 1'b1; flit_in_vc = 2'd2; flit_in = mk(2'b00, 5'b00000, 25'h32);
        step();
        flit_in_valid = 1'b0; #1;
        check_val("drop_req", sa_requests, 0);
        check_val("drop_proto_pre", proto_err, 0);
        step();
        check_val("drop_cvld", credit_out_valid, 1);
        check_val("drop_cvc", credit_out_vc, 2'd2);
        check_val("drop_fvld", flit_out_valid, 0);
        check_val("drop_proto", proto_err, 1);
        step();
        check_val("drop_cvld_once", credit_out_valid, 0);

        // Backpressure on route 00010, then a two-hot grant
        do_reset();
        outport_ready = 5'b11101;
        fh = mk(2'b01, 5'b00010, 25'h40);
        flit_in_valid = 1'b1; flit_in_vc = 2'd0; flit_in = fh;
        step();
        flit_in = mk(2'b00, 5'b00000, 25'h41);
        step();
        flit_in_valid = 1'b0; #1;
        check_val("bp_req_blocked", sa_requests[0], 5'b00000);
        outport_ready = 5'b11111; #1;
        check_val("bp_req_open", sa_requests[0], 5'b00010);
        sa_grant = 4'b0011;
        step();
        check_val("g2_gerr", grant_err, 1);
        check_val("g2_fvld", flit_out_valid, 0);
        check_val("g2_cvld", credit_out_valid, 0);
        sa_grant = 4'b0001;
        step();
        check_out("g2_head_kept", fh, 5'b00010, 2'd0);
        sa_grant = 4'b0000;

        // Grant to an empty VC
        do_reset();
        check_val("gempty_pre", grant_err, 0);
        sa_grant = 4'b0100;
        step();
        sa_grant = 4'b0000;
        check_val("gempty_gerr", grant_err, 1);
        check_val("gempty_fvld", flit_out_valid, 0);
        check_val("gempty_cvld", credit_out_valid, 0);

        // Asynchronous reset mid-packet on VC3, then a fresh packet
        do_reset();
        fh = mk(2'b01, 5'b01000, 25'h50);
        flit_in_valid = 1'b1; flit_in_vc = 2'd3;
        flit_in = fh; step();
        flit_in = mk(2'b00, 5'b00000, 25'h51); step();
        flit_in = mk(2'b00, 5'b00000, 25'h52); step();
        flit_in_valid = 1'b0; sa_grant = 4'b1000;
        step();
        sa_grant = 4'b0000;
        check_out("arst_pre", fh, 5'b01000, 2'd3);
        #1 reset = 1'b0;
        #1 check_quiet("arst");
        step();
        reset = 1'b1;
        fh = mk(2'b11, 5'b00001, 25'h60);
        flit_in_valid = 1'b1; flit_in_vc = 2'd3; flit_in = fh;
        step();
        flit_in_valid = 1'b0;
        step();
        check_val("arst_new_req", sa_requests[3], 5'b00001);
        sa_grant = 4'b1000;
        step();
        sa_grant = 4'b0000;
        check_out("arst_new", fh, 5'b00001, 2'd3);
        #1;
        check_val("arst_new_idle", sa_requests[3], 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
